// File: rtl/frame_pixel_streamer.sv
// Reads one frame from a 1-cycle-latency frame RAM and streams it in raster order
// on a valid/ready pixel stream tagged with sof/eol/eof, through a 2-entry skid FIFO.
module frame_pixel_streamer #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic [1:0]            dbg_state
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam int EW = DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Stream handshake: a pixel transfers on a rising edge where pix_valid & pix_ready;
  // pix_valid never drops and pix_* never change while a pixel waits for pix_ready.

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            inflight;
  logic            sof_d, eol_d, eof_d;
  logic [EW-1:0]   fifo_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            pop, push, last_read;
  logic [EW-1:0]   head;

  assign pop       = pix_valid & pix_ready;
  assign push      = inflight;
  assign last_read = (row == ROW_LAST) && (col == COL_LAST);
  assign busy      = (state == STREAM) || (state == DRAIN);
  assign done      = (state == FINISH);
  assign dbg_state = state;

  // Occupancy plus the read still in flight must leave room for the next read.
  always_comb begin
    rd_en = 1'b0;
    if (state == STREAM)
      rd_en = (({1'b0, count} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;
  end

  assign pix_valid = (count != 2'd0);
  assign head      = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign pix_data  = head[EW-1:3];
  assign pix_sof   = head[2];
  assign pix_eol   = head[1];
  assign pix_eof   = head[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_addr  <= '0;
      col      <= '0;
      row      <= '0;
      inflight <= 1'b0;
      sof_d    <= 1'b0;
      eol_d    <= 1'b0;
      eof_d    <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= rd_en;
      sof_d    <= (row == '0) && (col == '0);
      eol_d    <= (col == COL_LAST);
      eof_d    <= last_read;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            rd_addr <= '0;
            col     <= '0;
            row     <= '0;
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (last_read) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        DRAIN:   if (pop && pix_eof) state <= FINISH;
        default: state <= IDLE;
      endcase

      if (push) begin
        fifo_mem[wr_ptr] <= {rd_data, sof_d, eol_d, eof_d};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

endmodule
